// File: rtl/instr_mem_loader.sv
// instr_mem_loader: UART byte-stream bootloader for the ARM instruction memory.
// A frame is SYNC_BYTE, N (number of words), 4*N little-endian payload bytes,
// then the XOR of all payload bytes. Each complete word is written to memory.
// The core is released from reset only after a frame with a good checksum.
//
// Handshake: a byte transfers on a rising CLK edge where RX_VALID & RX_READY.
// The completed word is copied into its own write register, so a byte can be
// accepted in the same cycle the previous word is being written. RX_READY is
// therefore low only during reset and the first cycle after it.
//
// STATE_DBG encoding: 0 IDLE, 1 LEN, 2 DATA, 3 CHK, 4 DONE, 5 ERR.
module instr_mem_loader #(
  parameter int          ADDR_W      = 7,
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
  parameter int          TIMEOUT_CYC = 100000
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [7:0]        RX_DATA,
  input  logic              RX_VALID,
  output logic              RX_READY,
  output logic              MEM_WE,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [31:0]       MEM_WDATA,
  output logic              CORE_RESET,
  output logic              LOAD_DONE,
  output logic              LOAD_ERR,
  output logic [ADDR_W:0]   WORD_COUNT,
  output logic [2:0]        STATE_DBG
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int TW    = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LEN  = 3'd1,
    S_DATA = 3'd2,
    S_CHK  = 3'd3,
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              ready_q;
  logic [23:0]       asm_q;      // first three bytes of the word being built
  logic [1:0]        byte_idx;
  logic [ADDR_W:0]   n_words;
  logic [ADDR_W:0]   word_cnt;
  logic [7:0]        xor_q;
  logic [TW-1:0]     tmo_cnt;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;

  logic accept;
  logic in_frame;
  logic timeout;
  logic len_bad;
  logic word_end;
  logic last_word;
  logic is_sync;

  assign accept    = RX_VALID & ready_q;
  assign in_frame  = (state == S_LEN) || (state == S_DATA) || (state == S_CHK);
  assign timeout   = in_frame & ~accept & (tmo_cnt == TW'(TIMEOUT_CYC - 1));
  assign len_bad   = (RX_DATA == 8'd0) || (int'(RX_DATA) > DEPTH);
  assign word_end  = (byte_idx == 2'd3);
  assign last_word = word_end && ((word_cnt + 1'b1) == n_words);
  assign is_sync   = (RX_DATA == SYNC_BYTE);

  assign MEM_WE     = we_q;
  assign MEM_ADDR   = addr_q;
  assign MEM_WDATA  = wdata_q;
  assign WORD_COUNT = word_cnt;

  // State register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state: moves only on accepted bytes, except for the inter-byte timeout.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE, S_ERR: begin
        if (accept && is_sync) state_nxt = S_LEN;
      end
      S_LEN: begin
        if (accept)       state_nxt = len_bad ? S_ERR : S_DATA;
        else if (timeout) state_nxt = S_ERR;
      end
      S_DATA: begin
        if (accept && last_word) state_nxt = S_CHK;
        else if (timeout)        state_nxt = S_ERR;
      end
      S_CHK: begin
        if (accept)       state_nxt = (RX_DATA == xor_q) ? S_DONE : S_ERR;
        else if (timeout) state_nxt = S_ERR;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Status outputs decoded from state; the core runs only after a good frame.
  always_comb begin
    RX_READY   = ready_q;
    CORE_RESET = (state != S_DONE);
    LOAD_DONE  = (state == S_DONE);
    LOAD_ERR   = (state == S_ERR);
    STATE_DBG  = state;
  end

  // Datapath: word assembly, checksum, write port and timeout counter.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      ready_q  <= 1'b0;
      asm_q    <= '0;
      byte_idx <= '0;
      n_words  <= '0;
      word_cnt <= '0;
      xor_q    <= '0;
      tmo_cnt  <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      ready_q <= 1'b1;
      we_q    <= 1'b0;

      // Idle time only counts inside a frame; any accepted byte restarts it.
      if (!in_frame || accept) tmo_cnt <= '0;
      else                     tmo_cnt <= tmo_cnt + 1'b1;

      if (accept) begin
        case (state)
          S_IDLE, S_DONE, S_ERR: begin
            if (is_sync) begin
              word_cnt <= '0;
              xor_q    <= '0;
              byte_idx <= '0;
            end
          end
          S_LEN: begin
            if (!len_bad) n_words <= (ADDR_W + 1)'(RX_DATA);
          end
          S_DATA: begin
            xor_q    <= xor_q ^ RX_DATA;
            byte_idx <= byte_idx + 1'b1;
            asm_q    <= {RX_DATA, asm_q[23:8]};
            if (word_end) begin
              we_q     <= 1'b1;
              addr_q   <= word_cnt[ADDR_W-1:0];
              wdata_q  <= {RX_DATA, asm_q};
              word_cnt <= word_cnt + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Testbench for instr_mem_loader: table of directed frames, hand-written
// timeout / reset / full-depth sequences, and random frames checked against a
// frame-level reference model.
module tb_instr_mem_loader;

  localparam int         ADDR_W = 7;
  localparam int         DEPTH  = 2 ** ADDR_W;
  localparam int         TMO    = 64;
  localparam logic [7:0] SYNC   = 8'hA5;
  localparam int         RW     = ADDR_W + 32;

  logic              CLK = 1'b0;
  logic              RESET;
  logic [7:0]        RX_DATA;
  logic              RX_VALID;
  logic              RX_READY;
  logic              MEM_WE;
  logic [ADDR_W-1:0] MEM_ADDR;
  logic [31:0]       MEM_WDATA;
  logic              CORE_RESET;
  logic              LOAD_DONE;
  logic              LOAD_ERR;
  logic [ADDR_W:0]   WORD_COUNT;
  logic [2:0]        STATE_DBG;

  instr_mem_loader #(
    .ADDR_W      (ADDR_W),
    .SYNC_BYTE   (SYNC),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .RX_DATA    (RX_DATA),
    .RX_VALID   (RX_VALID),
    .RX_READY   (RX_READY),
    .MEM_WE     (MEM_WE),
    .MEM_ADDR   (MEM_ADDR),
    .MEM_WDATA  (MEM_WDATA),
    .CORE_RESET (CORE_RESET),
    .LOAD_DONE  (LOAD_DONE),
    .LOAD_ERR   (LOAD_ERR),
    .WORD_COUNT (WORD_COUNT),
    .STATE_DBG  (STATE_DBG)
  );

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  logic [RW-1:0] exp_q[$];   // expected {addr, data} writes, in order
  logic [RW-1:0] wr_log[$];  // writes observed since last clear
  logic [7:0]    tx_q[$];    // byte stream to send

  // model results for the last frame in tx_q
  logic m_done = 1'b0;
  logic m_err  = 1'b0;
  int   m_wc   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard on the write port ----------------
  always @(negedge CLK) begin
    if (MEM_WE === 1'b1) begin
      wr_log.push_back({MEM_ADDR, MEM_WDATA});
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected none", MEM_ADDR, MEM_WDATA);
      end else begin
        logic [RW-1:0] e;
        e = exp_q.pop_front();
        if ({MEM_ADDR, MEM_WDATA} !== e) begin
          n_bad++;
          $display("FAIL write: got addr %0h data %0h expected addr %0h data %0h",
                   MEM_ADDR, MEM_WDATA, e[RW-1:32], e[31:0]);
        end
      end
    end
  end

  // ---------------- reference model ----------------
  // Walks the byte stream by the frame rules: non-sync bytes between frames
  // are dropped, bad lengths fail at once, each 4 payload bytes make a word.
  task automatic model_stream();
    int i;
    logic [7:0]  n;
    logic [7:0]  x;
    logic [31:0] w;
    i = 0;
    while (i < tx_q.size()) begin
      if (tx_q[i] != SYNC) begin
        i++;
        continue;
      end
      m_done = 1'b0; m_err = 1'b0; m_wc = 0;
      i++;
      n = tx_q[i];
      i++;
      if (n == 8'd0 || int'(n) > DEPTH) begin
        m_err = 1'b1;
        continue;
      end
      x = 8'd0;
      for (int k = 0; k < int'(n); k++) begin
        w = {tx_q[i+3], tx_q[i+2], tx_q[i+1], tx_q[i]};
        x = x ^ tx_q[i] ^ tx_q[i+1] ^ tx_q[i+2] ^ tx_q[i+3];
        exp_q.push_back({ADDR_W'(k), w});
        m_wc++;
        i += 4;
      end
      if (tx_q[i] == x) m_done = 1'b1;
      else              m_err  = 1'b1;
      i++;
    end
  endtask

  // ---------------- drivers ----------------
  task automatic send_byte(input logic [7:0] b);
    int guard;
    @(negedge CLK);
    RX_DATA  = b;
    RX_VALID = 1'b1;
    guard    = 0;
    while (RX_READY !== 1'b1 && guard < 50) begin
      @(negedge CLK);
      guard++;
    end
    if (RX_READY !== 1'b1) begin
      n_cmp++;
      n_bad++;
      $display("FAIL rx_ready_wait: got ready %b expected 1 within 50 cycles", RX_READY);
    end
    @(posedge CLK);
    #1 RX_VALID = 1'b0;
  endtask

  // Model the stream, send it with optional random idle gaps, let it settle.
  task automatic run_stream(input int gap_max);
    model_stream();
    wr_log.delete();
    foreach (tx_q[i]) begin
      send_byte(tx_q[i]);
      if (gap_max > 0) repeat ($urandom_range(0, gap_max)) @(negedge CLK);
    end
    repeat (2) @(negedge CLK);
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_done"},       LOAD_DONE,   m_done);
    chk({tag, "_err"},        LOAD_ERR,    m_err);
    chk({tag, "_core_reset"}, CORE_RESET,  !m_done);
    chk({tag, "_word_count"}, WORD_COUNT,  m_wc);
    chk({tag, "_missing"},    exp_q.size(), 0);
    exp_q.delete();
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    string       name;
    int          len;
    logic [7:0]  b [16];
    logic        done;
    logic        err;
    int          wc;
    int          nwr;
    logic [31:0] w0;
  } vec_t;

  vec_t tbl[5];

  task automatic set_vec(input int idx, input string name, input int len,
                         input logic [127:0] bytes, input logic done, input logic err,
                         input int wc, input int nwr, input logic [31:0] w0);
    tbl[idx].name = name;
    tbl[idx].len  = len;
    for (int i = 0; i < 16; i++) tbl[idx].b[i] = bytes[127-8*i -: 8];
    tbl[idx].done = done;
    tbl[idx].err  = err;
    tbl[idx].wc   = wc;
    tbl[idx].nwr  = nwr;
    tbl[idx].w0   = w0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    RESET    = 1'b1;
    RX_DATA  = 8'h00;
    RX_VALID = 1'b0;

    set_vec(0, "good_frame", 11, 128'hA5_02_04_12_9F_E5_FE_FF_FF_EA_78_00_00_00_00_00,
            1'b1, 1'b0, 2, 2, 32'hE59F1204);
    set_vec(1, "bad_chk",    11, 128'hA5_02_04_12_9F_E5_FE_FF_FF_EA_79_00_00_00_00_00,
            1'b0, 1'b1, 2, 2, 32'hE59F1204);
    set_vec(2, "len_zero",    2, 128'hA5_00_00_00_00_00_00_00_00_00_00_00_00_00_00_00,
            1'b0, 1'b1, 0, 0, 32'h0);
    set_vec(3, "len_129",     2, 128'hA5_81_00_00_00_00_00_00_00_00_00_00_00_00_00_00,
            1'b0, 1'b1, 0, 0, 32'h0);
    set_vec(4, "junk_sync",   9, 128'h55_3C_A5_01_A5_A5_A5_A5_00_00_00_00_00_00_00_00,
            1'b1, 1'b0, 1, 1, 32'hA5A5A5A5);

    // reset state
    repeat (3) @(negedge CLK);
    chk("rst_rx_ready",   RX_READY,   0);
    chk("rst_mem_we",     MEM_WE,     0);
    chk("rst_mem_addr",   MEM_ADDR,   0);
    chk("rst_mem_wdata",  MEM_WDATA,  0);
    chk("rst_core_reset", CORE_RESET, 1);
    chk("rst_load_done",  LOAD_DONE,  0);
    chk("rst_load_err",   LOAD_ERR,   0);
    chk("rst_word_count", WORD_COUNT, 0);
    chk("rst_state",      STATE_DBG,  0);
    RESET = 1'b0;
    @(negedge CLK);
    chk("ready_after_release", RX_READY, 1);

    // directed frames
    for (int t = 0; t < 5; t++) begin
      tx_q.delete();
      for (int i = 0; i < tbl[t].len; i++) tx_q.push_back(tbl[t].b[i]);
      run_stream(0);
      chk({tbl[t].name, "_done"},       LOAD_DONE,     tbl[t].done);
      chk({tbl[t].name, "_err"},        LOAD_ERR,      tbl[t].err);
      chk({tbl[t].name, "_core_reset"}, CORE_RESET,    !tbl[t].done);
      chk({tbl[t].name, "_word_count"}, WORD_COUNT,    tbl[t].wc);
      chk({tbl[t].name, "_nwrites"},    wr_log.size(), tbl[t].nwr);
      if (wr_log.size() > 0) chk({tbl[t].name, "_word0"}, wr_log[0][31:0], tbl[t].w0);
      chk({tbl[t].name, "_missing"},    exp_q.size(),  0);
      exp_q.delete();
    end

    // timeout inside the payload, then a clean frame
    wr_log.delete();
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h11); send_byte(8'h22);
    repeat (TMO - 2) @(negedge CLK);
    chk("tmo_not_yet", LOAD_ERR, 0);
    repeat (4) @(negedge CLK);
    chk("tmo_err",        LOAD_ERR,      1);
    chk("tmo_core_reset", CORE_RESET,    1);
    chk("tmo_state",      STATE_DBG,     5);
    chk("tmo_no_write",   wr_log.size(), 0);
    tx_q = '{8'hA5, 8'h01, 8'h78, 8'h56, 8'h34, 8'h12, 8'h08};
    run_stream(0);
    check_model("after_tmo");

    // reset pulse after the second payload byte, then a full frame
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h04); send_byte(8'h12);
    RESET = 1'b1;
    #1;
    chk("midrst_core_reset", CORE_RESET, 1);
    chk("midrst_word_count", WORD_COUNT, 0);
    chk("midrst_state",      STATE_DBG,  0);
    chk("midrst_rx_ready",   RX_READY,   0);
    chk("midrst_done",       LOAD_DONE,  0);
    @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    tx_q = '{8'hA5, 8'h02, 8'h04, 8'h12, 8'h9F, 8'hE5, 8'hFE, 8'hFF, 8'hFF, 8'hEA, 8'h78};
    run_stream(0);
    check_model("after_midrst");

    // full-depth frame: last address must be DEPTH-1
    tx_q.delete();
    tx_q.push_back(SYNC);
    tx_q.push_back(8'(DEPTH));
    for (int i = 0; i < 4 * DEPTH; i++) tx_q.push_back(8'($urandom_range(0, 255)));
    begin
      logic [7:0] x;
      x = 8'd0;
      for (int i = 2; i < 2 + 4 * DEPTH; i++) x = x ^ tx_q[i];
      tx_q.push_back(x);
    end
    run_stream(0);
    chk("full_nwrites", wr_log.size(), DEPTH);
    if (wr_log.size() > 0) chk("full_last_addr", wr_log[wr_log.size()-1][RW-1:32], DEPTH - 1);
    check_model("full_depth");

    // random frames with junk, gaps, bad checksums and bad lengths
    for (int r = 0; r < 20; r++) begin
      logic [7:0] x;
      logic [7:0] b;
      int n;
      tx_q.delete();
      repeat ($urandom_range(0, 2)) begin
        b = 8'($urandom_range(0, 255));
        if (b == SYNC) b = 8'h5A;
        tx_q.push_back(b);
      end
      tx_q.push_back(SYNC);
      if ($urandom_range(0, 7) == 0) begin
        tx_q.push_back(($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(DEPTH + 1, 255)));
      end else begin
        n = $urandom_range(1, 6);
        tx_q.push_back(8'(n));
        x = 8'd0;
        for (int i = 0; i < 4 * n; i++) begin
          b = 8'($urandom_range(0, 255));
          x = x ^ b;
          tx_q.push_back(b);
        end
        if ($urandom_range(0, 3) == 0) x = x ^ 8'(1 << $urandom_range(0, 7));
        tx_q.push_back(x);
      end
      run_stream(2);
      check_model($sformatf("rand%0d", r));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // watchdog so the run always ends
  initial begin
    #2000000;
    n_cmp++;
    n_bad++;
    $display("FAIL watchdog: got no end of test expected finish before 2 ms");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
